// File: rtl/tt_um_algofoogle_ctrcheck.sv
// ============================================================================
//  Module      : tt_um_algofoogle_ctrcheck
//  Description : Counter-sequence checker. Samples a 4-bit nibble every cycle,
//                predicts the next value (+1 or -1 mod 16), hunts for four
//                consecutive valid steps to lock, then flags and counts any
//                mismatches seen while locked.
//  Options     : CTRCHECK_WIDE_ERR_EN - 16-bit error counter, byte selected
//                onto uo_out by ui_in[4]. Undefined: 8-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_algofoogle_ctrcheck (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

`ifdef CTRCHECK_WIDE_ERR_EN
    localparam int ERR_W = 16;
`else
    localparam int ERR_W = 8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_run;
    logic [1:0]         w_run_nxt;
    logic [3:0]         r_sq;
    logic [3:0]         r_prev;
    logic               r_dir;
    logic               r_mismatch;
    logic               w_mismatch_nxt;
    logic [ERR_W-1:0]   r_err;
    logic               w_err_inc;

    logic               w_chk_en;
    logic               w_err_clr;
    logic [3:0]         w_pred;
    logic               w_match;
    logic [3:0]         w_exp_out;

    assign w_chk_en  = ui_in[7];
    assign w_err_clr = ui_in[5];

    // The direction travels with its sample so a dir change applies to the
    // very next compare; the reference is always the real previous sample.
    assign w_pred  = r_dir ? (r_prev - 4'd1) : (r_prev + 4'd1);
    assign w_match = (r_sq == w_pred);

    // Sample pipeline: nibble, its direction, and the previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq   <= 4'd0;
            r_prev <= 4'd0;
            r_dir  <= 1'b0;
        end else begin
            r_sq   <= ui_in[3:0];
            r_prev <= r_sq;
            r_dir  <= ui_in[6];
        end
    end

    // State, run counter and registered mismatch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_run      <= 2'd0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= w_run_nxt;
            r_mismatch <= w_mismatch_nxt;
        end
    end

    // Next-state logic: hunt for four good steps, then watch for a break.
    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_mismatch_nxt = 1'b0;
        w_err_inc      = 1'b0;
        if (!w_chk_en) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_HUNT;
                    w_run_nxt   = 2'd0;
                end
                ST_HUNT: begin
                    if (w_match) begin
                        if (r_run == 2'd3) begin
                            w_state_nxt = ST_LOCKED;
                            w_run_nxt   = 2'd0;
                        end else begin
                            w_run_nxt = r_run + 2'd1;
                        end
                    end else begin
                        w_run_nxt = 2'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_match) begin
                        w_mismatch_nxt = 1'b1;
                        w_err_inc      = 1'b1;
                        w_state_nxt    = ST_HUNT;
                        w_run_nxt      = 2'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Saturating error counter; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (w_err_clr) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
            r_err <= r_err + ERR_W'(1);
        end
    end

    // Value the next sample will be checked against; blank while idle so the
    // status port reads zero in and right after reset.
    assign w_exp_out = (r_state == ST_IDLE) ? 4'd0 :
                       (ui_in[6] ? (r_sq - 4'd1) : (r_sq + 4'd1));

`ifdef CTRCHECK_WIDE_ERR_EN
    assign uo_out = ui_in[4] ? r_err[15:8] : r_err[7:0];
    logic w_unused;
    assign w_unused = &{1'b0, uio_in, ena};
`else
    assign uo_out = r_err;
    logic w_unused;
    assign w_unused = &{1'b0, uio_in, ena, ui_in[4]};
`endif

    assign uio_out = {r_state, (r_state == ST_LOCKED), r_mismatch, w_exp_out};
    assign uio_oe  = 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_algofoogle_ctrcheck.sv
// ============================================================================
//  Module      : tb_tt_um_algofoogle_ctrcheck
//  Description : Self-checking bench for the counter-sequence checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_algofoogle_ctrcheck;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    tt_um_algofoogle_ctrcheck dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ui;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;

    localparam int NVEC = 40;
    vec_t vecs [NVEC];
    vec_t sb [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one record, let one edge pass, compare against the queued result.
    task automatic apply(input int idx);
        vec_t e;
        ui_in = vecs[idx].ui;
        sb.push_back(vecs[idx]);
        @(posedge clk);
        #2;
        e = sb.pop_front();
        check($sformatf("vec%0d uo_out", idx), int'(uo_out), int'(e.uo));
        check($sformatf("vec%0d uio_out", idx), int'(uio_out), int'(e.uio));
    endtask

    int mm_seen;

    task automatic drive_up(input logic [3:0] nib);
        ui_in = {4'b1000, nib};
        @(posedge clk);
        #2;
        if (uio_out[4]) mm_seen++;
    endtask

    task automatic do_reset();
        ui_in = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] v;

        // {ui_in, expected uo_out, expected uio_out after the next edge}
        vecs[0]  = '{8'h80, 8'h00, 8'h41};
        vecs[1]  = '{8'h81, 8'h00, 8'h42};
        vecs[2]  = '{8'h82, 8'h00, 8'h43};
        vecs[3]  = '{8'h83, 8'h00, 8'h44};
        vecs[4]  = '{8'h84, 8'h00, 8'h45};
        vecs[5]  = '{8'h85, 8'h00, 8'hA6};
        vecs[6]  = '{8'h86, 8'h00, 8'hA7};
        vecs[7]  = '{8'h87, 8'h00, 8'hA8};
        vecs[8]  = '{8'h88, 8'h00, 8'hA9};
        vecs[9]  = '{8'h89, 8'h00, 8'hAA};
        vecs[10] = '{8'h8A, 8'h00, 8'hAB};
        vecs[11] = '{8'h8B, 8'h00, 8'hAC};
        vecs[12] = '{8'h8C, 8'h00, 8'hAD};
        vecs[13] = '{8'h8D, 8'h00, 8'hAE};
        vecs[14] = '{8'h8E, 8'h00, 8'hAF};
        vecs[15] = '{8'h8F, 8'h00, 8'hA0};
        vecs[16] = '{8'h80, 8'h00, 8'hA1};
        vecs[17] = '{8'h81, 8'h00, 8'hA2};
        vecs[18] = '{8'hC1, 8'h00, 8'hA0};
        vecs[19] = '{8'hC0, 8'h01, 8'h5F};
        vecs[20] = '{8'hCF, 8'h01, 8'h4E};
        vecs[21] = '{8'hCE, 8'h01, 8'h4D};
        vecs[22] = '{8'hCD, 8'h01, 8'h4C};
        vecs[23] = '{8'hCC, 8'h01, 8'hAB};
        vecs[24] = '{8'h8D, 8'h01, 8'hAE};
        vecs[25] = '{8'h8E, 8'h01, 8'hAF};
        vecs[26] = '{8'h80, 8'h01, 8'hA1};
        vecs[27] = '{8'h81, 8'h02, 8'h52};
        vecs[28] = '{8'h82, 8'h02, 8'h43};
        vecs[29] = '{8'h89, 8'h02, 8'h4A};
        vecs[30] = '{8'h8A, 8'h02, 8'h4B};
        vecs[31] = '{8'h8B, 8'h02, 8'h4C};
        vecs[32] = '{8'h8C, 8'h02, 8'h4D};
        vecs[33] = '{8'h8D, 8'h02, 8'h4E};
        vecs[34] = '{8'h8E, 8'h02, 8'hAF};
        vecs[35] = '{8'h80, 8'h02, 8'hA1};
        vecs[36] = '{8'hA1, 8'h00, 8'h52};
        vecs[37] = '{8'h82, 8'h00, 8'h43};
        vecs[38] = '{8'h03, 8'h00, 8'h00};
        vecs[39] = '{8'h84, 8'h00, 8'h45};

        uio_in = 8'h00;
        ena    = 1'b1;
        ui_in  = 8'h00;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset uo_out", int'(uo_out), 0);
        check("reset uio_out", int'(uio_out), 0);
        check("uio_oe", int'(uio_oe), 8'hFF);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Lock, wrap, direction flip, locked glitch, HUNT glitch, clear, chk_en off.
        for (int i = 0; i < NVEC; i++) apply(i);

        // 300 locked mismatches: each block jumps by 2 then steps +1 four times.
        do_reset();
        for (int i = 0; i < 6; i++) apply(i);
        mm_seen = 0;
        v = 4'd5;
        for (int b = 0; b < 300; b++) begin
            v = v + 4'd2;
            drive_up(v);
            for (int k = 0; k < 4; k++) begin
                v = v + 4'd1;
                drive_up(v);
            end
        end
        for (int k = 0; k < 3; k++) begin
            v = v + 4'd1;
            drive_up(v);
        end
        check("mismatch pulses", mm_seen, 300);
        check("locked after stream", int'(uio_out[5]), 1);
`ifdef CTRCHECK_WIDE_ERR_EN
        ui_in[4] = 1'b1;
        #1;
        check("err hi byte", int'(uo_out), 8'h01);
        ui_in[4] = 1'b0;
        #1;
        check("err lo byte", int'(uo_out), 8'h2C);
`else
        check("err saturated", int'(uo_out), 8'hFF);
        ui_in[4] = 1'b1;
        #1;
        check("err sel ignored", int'(uo_out), 8'hFF);
        ui_in[4] = 1'b0;
        #1;
`endif

        // Asynchronous reset mid-cycle while locked.
        rst_n = 1'b0;
        #1;
        check("async rst uo_out", int'(uo_out), 0);
        check("async rst uio_out", int'(uio_out), 0);
        ui_in = 8'h00;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) apply(i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
